// File: rtl/stream_arb_wrr_pkg.sv
// Shared helpers for the weighted round-robin stream arbiter (index width, pointer wrap,
// burst credit). Burst state is a struct built in the top from these widths.
package stream_arb_wrr_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Beats left after the first one of a new burst: max(weight,1)-1.
  function automatic int unsigned burst_rem(input int unsigned weight);
    return (weight == 0) ? 0 : weight - 1;
  endfunction

endpackage

// File: rtl/stream_arb_wrr_select.sv
// Round-robin pick: first valid input at or after ptr, wrapping past the top index.
// Rotates the valid vector by ptr, priority-encodes, then adds ptr back.
module stream_arb_wrr_select import stream_arb_wrr_pkg::*; #(
  parameter int unsigned N_INP = 4,
  parameter int unsigned IDX_W = idx_width(N_INP)
) (
  input  logic [N_INP-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_INP-1:0] doubled;
  logic [N_INP-1:0]   rotated;
  int                 offset;
  int                 pos;

  assign doubled = {valid, valid};

  always_comb begin
    rotated = N_INP'(doubled >> ptr);
    any     = 1'b0;
    offset  = 0;
    // Scan downward so the smallest offset from ptr is the one that sticks.
    for (int k = N_INP - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        any    = 1'b1;
        offset = k;
      end
    end
    pos = int'(ptr) + offset;
    if (pos >= int'(N_INP)) pos = pos - int'(N_INP);
    idx = IDX_W'(pos);
  end

endmodule

// File: rtl/stream_arbiter_wrr.sv
// Weighted round-robin valid/ready stream arbiter with flush and granted-index output.
// Define ST_ARB_WRR_PKT_EN to add last ports and count weights in packets instead of beats.
module stream_arbiter_wrr import stream_arb_wrr_pkg::*; #(
  parameter type         DATA_T   = logic,
  parameter int unsigned N_INP    = 4,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned IDX_W   = idx_width(N_INP)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [N_INP*WEIGHT_W-1:0] weight_i,
  input  DATA_T [N_INP-1:0]         inp_data_i,
  input  logic [N_INP-1:0]          inp_valid_i,
`ifdef ST_ARB_WRR_PKT_EN
  input  logic [N_INP-1:0]          inp_last_i,
  output logic                      oup_last_o,
`endif
  output logic [N_INP-1:0]          inp_ready_o,
  output DATA_T                     oup_data_o,
  output logic                      oup_valid_o,
  input  logic                      oup_ready_i,
  output logic [IDX_W-1:0]          oup_idx_o
);

  typedef struct packed {
    logic [IDX_W-1:0]    ptr;
    logic [WEIGHT_W-1:0] cnt;
    logic                lock;
    logic [IDX_W-1:0]    lock_idx;
  } arb_state_t;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    pick_idx, sel;
  logic                pick_any, blocked, handshake, last_beat;
  logic [WEIGHT_W-1:0] weight_sel;

  stream_arb_wrr_select #(
    .N_INP (N_INP),
    .IDX_W (IDX_W)
  ) u_select (
    .valid (inp_valid_i),
    .ptr   (state_q.ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign blocked     = rst_i | flush_i;
  assign sel         = state_q.lock ? state_q.lock_idx : pick_idx;
  assign oup_valid_o = pick_any & ~blocked;
  assign oup_data_o  = inp_data_i[sel];
  assign oup_idx_o   = sel;
  assign handshake   = oup_valid_o & oup_ready_i;
  assign weight_sel  = weight_i[sel*WEIGHT_W +: WEIGHT_W];

`ifdef ST_ARB_WRR_PKT_EN
  assign last_beat  = inp_last_i[sel];
  assign oup_last_o = last_beat;
`else
  assign last_beat  = 1'b1;
`endif

  always_comb begin
    inp_ready_o = '0;
    if (!blocked) inp_ready_o[sel] = oup_ready_i;
  end

  // Lock holds the grant through back-pressure or an open packet; credit moves only on last beats.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = '0;
    end else if (oup_valid_o && !oup_ready_i) begin
      state_d.lock     = 1'b1;
      state_d.lock_idx = sel;
    end else if (handshake) begin
      state_d.lock = 1'b0;
      if (!last_beat) begin
        state_d.lock     = 1'b1;
        state_d.lock_idx = sel;
      end else if (sel == state_q.ptr && state_q.cnt != '0) begin
        state_d.cnt = state_q.cnt - 1'b1;
        if (state_q.cnt == WEIGHT_W'(1)) state_d.ptr = IDX_W'(wrap_inc(32'(sel), N_INP));
      end else if (burst_rem(32'(weight_sel)) == 0) begin
        state_d.ptr = IDX_W'(wrap_inc(32'(sel), N_INP));
        state_d.cnt = '0;
      end else begin
        state_d.ptr = sel;
        state_d.cnt = WEIGHT_W'(burst_rem(32'(weight_sel)));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= '0;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_stream_arbiter_wrr.sv
// Bench for stream_arbiter_wrr: directed scenarios plus random traffic against a burst-owner model.
// Compile with ST_ARB_WRR_PKT_EN to also exercise packet mode.
module tb_stream_arbiter_wrr;

  localparam int N  = 4;
  localparam int WW = 4;
`ifdef ST_ARB_WRR_PKT_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  typedef logic [7:0] data_t;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, oup_valid_o, oup_ready_i;
  logic [N*WW-1:0] weight_i;
  data_t [N-1:0]   inp_data_i;
  logic [N-1:0]    inp_valid_i, inp_ready_o, inp_last_i;
  data_t           oup_data_o;
  logic [1:0]      oup_idx_o;
`ifdef ST_ARB_WRR_PKT_EN
  logic            oup_last_o;
`endif

  stream_arbiter_wrr #(
    .DATA_T   (data_t),
    .N_INP    (N),
    .WEIGHT_W (WW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .weight_i    (weight_i),
    .inp_data_i  (inp_data_i),
    .inp_valid_i (inp_valid_i),
`ifdef ST_ARB_WRR_PKT_EN
    .inp_last_i  (inp_last_i),
    .oup_last_o  (oup_last_o),
`endif
    .inp_ready_o (inp_ready_o),
    .oup_data_o  (oup_data_o),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_idx_o   (oup_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_vec = 0;
  int         n_err = 0;
  // Model: the input owning the current burst, beats it may still take, and a held grant.
  int         m_owner, m_left, m_hold;
  logic [N-1:0] pending;
  logic [31:0]  obs_idx, obs_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_owner = N - 1;
    m_left  = 0;
    m_hold  = -1;
  endtask

  function automatic int modelSel();
    int start;
    if (m_hold >= 0) return m_hold;
    start = (m_left > 0) ? m_owner : (m_owner + 1) % N;
    for (int k = 0; k < N; k++)
      if (inp_valid_i[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // One clock: present inputs (sources with an unaccepted beat keep it), check, update model.
  task automatic applyStimulus(input logic [N-1:0] want_valid, input logic ready,
                               input logic flush, input logic [N-1:0] want_last);
    logic blk, ev, lst;
    int   sel, w;
    for (int i = 0; i < N; i++) begin
      if (!pending[i]) begin
        inp_valid_i[i] = want_valid[i];
        inp_data_i[i]  = 8'($urandom);
        inp_last_i[i]  = want_last[i];
      end
    end
    oup_ready_i = ready;
    flush_i     = flush;
    #1;
    blk = rst_i | flush_i;
    ev  = (|inp_valid_i) & ~blk;
    sel = modelSel();
    obs_idx  = 32'(oup_idx_o);
    obs_data = 32'(oup_data_o);
    checkOutput("valid", 32'(oup_valid_o), 32'(ev));
    if (ev) begin
      checkOutput("idx", 32'(oup_idx_o), 32'(sel));
      checkOutput("data", 32'(oup_data_o), 32'(inp_data_i[sel]));
      checkOutput("ready", 32'(inp_ready_o), ready ? (32'd1 << sel) : 32'd0);
`ifdef ST_ARB_WRR_PKT_EN
      checkOutput("last", 32'(oup_last_o), 32'(inp_last_i[sel]));
`endif
    end else if (blk) begin
      checkOutput("ready_blk", 32'(inp_ready_o), 32'd0);
    end
    pending = inp_valid_i;
    if (blk) begin
      modelReset();
    end else if (ev) begin
      if (!ready) begin
        m_hold = sel;
      end else begin
        pending[sel] = 1'b0;
        lst = PKT ? inp_last_i[sel] : 1'b1;
        if (!lst) begin
          m_hold = sel;
        end else begin
          m_hold = -1;
          w = int'(weight_i[sel*WW +: WW]);
          if (sel == m_owner && m_left > 0) m_left--;
          else begin
            m_owner = sel;
            m_left  = ((w == 0) ? 1 : w) - 1;
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && pending != '0; c++) applyStimulus('0, 1'b1, 1'b0, '1);
    checkOutput("drain_done", 32'(pending), 32'd0);
  endtask

  initial begin
    int    seq1 [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
    logic [31:0] d0;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    oup_ready_i = 1'b0;
    inp_valid_i = '0;
    inp_data_i  = '0;
    inp_last_i  = '1;
    pending     = '0;
    weight_i    = {4'd1, 4'd3, 4'd2, 4'd1};
    modelReset();
    @(posedge clk_i);
    #1;

    // Reset state: nothing offered while reset is held.
    applyStimulus('1, 1'b1, 1'b0, '1);
    applyStimulus('1, 1'b1, 1'b0, '1);
    rst_i = 1'b0;

    $display("[TB] weighted rotation, all inputs valid");
    for (int k = 0; k < 10; k++) begin
      applyStimulus('1, 1'b1, 1'b0, '1);
      checkOutput("t1_seq", obs_idx, 32'(seq1[k]));
    end

    $display("[TB] flush mid-burst");
    applyStimulus('1, 1'b1, 1'b0, '1);
    checkOutput("t4_pre", obs_idx, 32'd2);
    applyStimulus('1, 1'b1, 1'b1, '1);
    applyStimulus('1, 1'b1, 1'b0, '1);
    checkOutput("t4_restart", obs_idx, 32'd0);
    drain();

    $display("[TB] back-pressure on a single input");
    applyStimulus(4'b0100, 1'b0, 1'b0, '1);
    d0 = obs_data;
    checkOutput("t2_idx0", obs_idx, 32'd2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, (k == 2), 1'b0, '1);
      checkOutput("t2_idx", obs_idx, 32'd2);
      checkOutput("t2_data", obs_data, d0);
    end
    applyStimulus('0, 1'b1, 1'b0, '1);
    checkOutput("t2_done", 32'(oup_valid_o), 32'd0);

    $display("[TB] grantee drops valid mid-burst");
    weight_i = {4'd1, 4'd3, 4'd3, 4'd1};
    applyStimulus('0, 1'b1, 1'b1, '1);
    applyStimulus(4'b1010, 1'b1, 1'b0, '1);
    checkOutput("t3_first", obs_idx, 32'd1);
    applyStimulus(4'b1000, 1'b1, 1'b0, '1);
    checkOutput("t3_switch", obs_idx, 32'd3);
    applyStimulus(4'b0010, 1'b1, 1'b0, '1);
    drain();

    $display("[TB] asynchronous reset while locked");
    applyStimulus(4'b1000, 1'b0, 1'b0, '1);
    applyStimulus(4'b1000, 1'b0, 1'b0, '1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("t5_valid", 32'(oup_valid_o), 32'd0);
    checkOutput("t5_ready", 32'(inp_ready_o), 32'd0);
    modelReset();
    @(posedge clk_i);
    #1;
    applyStimulus(4'b1001, 1'b1, 1'b0, '1);
    rst_i = 1'b0;
    applyStimulus(4'b1001, 1'b1, 1'b0, '1);
    checkOutput("t5_restart", obs_idx, 32'd0);
    drain();

`ifdef ST_ARB_WRR_PKT_EN
    $display("[TB] packet hold");
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    applyStimulus('0, 1'b1, 1'b1, '1);
    applyStimulus(4'b0011, 1'b1, 1'b0, 4'b0010);
    checkOutput("t6_b0", obs_idx, 32'd0);
    applyStimulus(4'b0011, 1'b1, 1'b0, 4'b0010);
    checkOutput("t6_b1", obs_idx, 32'd0);
    applyStimulus(4'b0011, 1'b1, 1'b0, 4'b0011);
    checkOutput("t6_b2", obs_idx, 32'd0);
    applyStimulus('0, 1'b1, 1'b0, '1);
    checkOutput("t6_next", obs_idx, 32'd1);
    drain();
`endif

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) weight_i = 16'($urandom);
      applyStimulus(N'($urandom), ($urandom % 4) != 0, ($urandom % 32) == 0, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
